// File: rtl/mult_accum.sv
// Saturating signed accumulator for Booth multiplier products; sums beats until in_last, then holds the group result.
// Latency: the group result appears one cycle after the last beat is accepted; one bubble cycle per group.
// Backpressure: in_ready is low while a result is held or in_clear is asserted; the result holds until out_ready.
module mult_accum #(
    parameter int Bits    = 64,
    parameter int AccBits = 2*Bits+8,
    parameter int CntBits = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*Bits-1:0]    in_prod,
    input  logic                 in_last,
    input  logic                 in_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AccBits-1:0]   out_sum,
    output logic [CntBits-1:0]   out_count,
    output logic                 out_ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam int                 ExtBits = AccBits + 1 - 2*Bits;
    localparam logic [AccBits-1:0] SAT_POS = {1'b0, {(AccBits-1){1'b1}}};
    localparam logic [AccBits-1:0] SAT_NEG = {1'b1, {(AccBits-1){1'b0}}};
    localparam logic [CntBits-1:0] CNT_MAX = '1;

    logic [1:0]         state_q, state_d;
    logic [AccBits-1:0] acc_q, acc_d;
    logic [CntBits-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [AccBits-1:0] out_sum_q, out_sum_d;
    logic [CntBits-1:0] out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [AccBits:0]   prod_ext;
    logic [AccBits:0]   sum_ext;
    logic               sat_hit;
    logic [AccBits-1:0] acc_next;
    logic [CntBits-1:0] cnt_next;
    logic               accept;

    // Sum carried one bit wider; differing top bits mean the signed result left the AccBits range.
    always_comb begin
        prod_ext = {{ExtBits{in_prod[2*Bits-1]}}, in_prod};
        sum_ext  = {acc_q[AccBits-1], acc_q} + prod_ext;
        sat_hit  = sum_ext[AccBits] ^ sum_ext[AccBits-1];
        if (sat_hit) begin
            acc_next = sum_ext[AccBits] ? SAT_NEG : SAT_POS;
        end else begin
            acc_next = sum_ext[AccBits-1:0];
        end
        cnt_next = (count_q == CNT_MAX) ? count_q : count_q + CntBits'(1);
    end

    always_comb begin
        in_ready = (state_q != HOLD) && !in_clear;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (state_q == HOLD) begin
            if (out_ready) begin
                state_d     = IDLE;
                acc_d       = '0;
                count_d     = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        end else if (in_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            acc_d   = acc_next;
            count_d = cnt_next;
            ovf_d   = ovf_q | sat_hit;
            if (in_last) begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
                out_sum_d   = acc_next;
                out_count_d = cnt_next;
                out_ovf_d   = ovf_q | sat_hit;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/mult_accum.md
Name: mult_accum

Overview:
- Sequential accumulator directly downstream of the radix-4 Booth multiplier. Consumes its signed 2*Bits-bit products over a valid/ready handshake.
- Sums a group of products, terminated by in_last, into a wider signed accumulator with saturation. Presents the group result on an output valid/ready handshake.
- Together with the multiplier, forms the dot-product / MAC datapath.

Parameters:
- Bits, 64, operand width of the upstream multiplier; products are 2*Bits wide.
- AccBits, 2*Bits+8, accumulator and result width; must be >= 2*Bits.
- CntBits, 16, width of the per-group beat counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_prod  input  2*Bits  signed two's-complement product from the multiplier.
- in_last  input  1  qualifies the beat as the final one of its group.
- in_clear  input  1  single-cycle abort: discard the partial group.
- out_valid  output  1  group result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  AccBits  signed group sum, saturated.
- out_count  output  CntBits  number of beats accumulated in the group.
- out_ovf  output  1  sticky flag: saturation occurred within the group.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, and takes priority over everything.
  - After reset: state=IDLE, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Reset asserted mid-group or while in HOLD drops the group and any pending result.
- States:
  - IDLE: no beats in the group yet.
  - ACCUM: at least one beat accumulated, in_last not yet seen.
  - HOLD: result presented on the output.
- in_ready:
  - in_ready = (state != HOLD) && !in_clear. This is combinational on in_clear only.
  - Accept = in_valid && in_ready.
- Accept, not last (IDLE or ACCUM):
  - acc <= sat(acc + sext(in_prod)).
  - count <= count+1, saturating at 2^CntBits-1.
  - ovf <= ovf | sat_hit.
  - Next state is ACCUM.
- Accept with in_last:
  - Accumulate the beat using the same rule.
  - Next state is HOLD.
  - On the next cycle: out_valid=1, with out_sum, out_count and out_ovf equal to the updated values.
  - Latency: last beat accepted in cycle t, so out_valid=1 in cycle t+1.
- A group of one beat with in_last set is legal; result is sext(in_prod), count 1.
- Saturation (signed, at AccBits):
  - Compute the sum at AccBits+1 bits.
  - If the top two bits differ, clamp: positive overflow to 2^(AccBits-1)-1, negative overflow to -2^(AccBits-1). Set sat_hit.
  - After a clamp, accumulation continues from the clamped value.
- HOLD:
  - Outputs stay stable while out_valid && !out_ready.
  - When out_valid && out_ready: next cycle out_valid=0, acc=0, count=0, ovf=0, state=IDLE.
  - in_ready is 0 throughout HOLD, including the handshake cycle, so there is no back-to-back overlap: one bubble per group.
  - out_sum, out_count and out_ovf hold their last values after the handshake until the next group result.
- in_clear:
  - In IDLE or ACCUM: next cycle acc=0, count=0, ovf=0, state=IDLE.
  - A concurrent in_valid beat is not accepted, because in_ready=0. Upstream must hold it.
  - In HOLD: ignored; the pending result is unaffected.
- Simultaneous events:
  - reset beats in_clear, which beats accept.
  - out_ready without out_valid is ignored.
- Width: in_prod is sign-extended by in_prod[2*Bits-1] to AccBits before the add.

Test Plan:
- Reset then a single-beat group: in_prod=0x...0005 with in_last -> cycle t+1 out_valid=1, out_sum=5, out_count=1, out_ovf=0; after out_ready, out_valid=0 and in_ready=1 one cycle later.
- Signed group: products 100, -300, 7 (last) -> out_sum=-193 (sign-extended to AccBits), out_count=3.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, no beat accepted; release -> result consumed, next beat accepted the following cycle.
- Saturation: AccBits=2*Bits, repeat the max positive product (0x7FFF...F) twice -> out_sum=2^(AccBits-1)-1, out_ovf=1. A subsequent group without overflow reports out_ovf=0.
- Clear: accumulate 10, 20, then in_clear with in_valid=1 and in_prod=99 -> beat not accepted; re-present 99 with last -> out_sum=99, out_count=1.
- Reset mid-group and reset in HOLD -> outputs return to reset values the next cycle; the next group starts from 0.
